// File: rtl/column_serializer_if.sv
`default_nettype none
// ------------------------------------------------------------------------
// column_serializer_if : framebuffer <-> column serializer signal bundle
// Rev 1.0
// ------------------------------------------------------------------------
interface column_serializer_if #(
  parameter int N_DRIVERS = 16,
  parameter int BITS      = 24,
  parameter int MUX       = 8
);
  localparam int CW = (MUX > 1) ? $clog2(MUX) : 1;

  logic                      clk_enable;
  logic [N_DRIVERS*BITS-1:0] data_in;
  logic                      driver_SOF;
  logic                      EOC;
  logic [N_DRIVERS-1:0]      sout;
  logic                      sclk_en;
  logic                      lat;
  logic [CW-1:0]             col_idx;
  logic                      busy;

  // master = framebuffer side, slave = serializer side
  modport master (
    output clk_enable, data_in, driver_SOF,
    input  EOC, sout, sclk_en, lat, col_idx, busy
  );

  modport slave (
    input  clk_enable, data_in, driver_SOF,
    output EOC, sout, sclk_en, lat, col_idx, busy
  );
endinterface
`default_nettype wire

// File: rtl/column_serializer.sv
`default_nettype none
// ------------------------------------------------------------------------
// column_serializer : shifts one column per driver lane MSB-first, then latches
// Rev 1.0
// ------------------------------------------------------------------------
module column_serializer #(
  parameter int N_DRIVERS = 16,
  parameter int BITS      = 24,
  parameter int MUX       = 8
) (
  input  wire logic           clk,
  input  wire logic           nrst,
  column_serializer_if.slave  bus
);
  localparam int CW = (MUX > 1) ? $clog2(MUX) : 1;
  localparam int BW = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int W  = N_DRIVERS * BITS;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SHIFT  = 3'd2,
    LATCH  = 3'd3,
    EOC_ST = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]   col_idx_q, col_idx_d;
  logic [W-1:0]    shreg_q, shreg_d;

  logic [W-1:0]          w_shifted;
  logic [N_DRIVERS-1:0]  w_msb;

  // Each lane shifts independently within its own BITS-wide word.
  for (genvar d = 0; d < N_DRIVERS; d++) begin : g_lane
    assign w_shifted[BITS*d +: BITS] = {shreg_q[BITS*d +: BITS-1], 1'b0};
    assign w_msb[d]                  = shreg_q[BITS*d + BITS - 1];
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      col_idx_q <= '0;
      shreg_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      col_idx_q <= col_idx_d;
      shreg_q   <= shreg_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    col_idx_d = col_idx_q;
    shreg_d   = shreg_q;
    if (bus.clk_enable) begin
      // A start-of-frame restarts from column 0 regardless of the current phase.
      if (bus.driver_SOF) begin
        state_d   = LOAD;
        col_idx_d = '0;
        bit_cnt_d = '0;
      end else begin
        case (state_q)
          IDLE: ;
          LOAD: begin
            shreg_d   = bus.data_in;
            bit_cnt_d = '0;
            state_d   = SHIFT;
          end
          SHIFT: begin
            shreg_d = w_shifted;
            if (bit_cnt_q == BW'(BITS - 1)) begin
              state_d = LATCH;
            end else begin
              bit_cnt_d = bit_cnt_q + BW'(1);
            end
          end
          LATCH: state_d = EOC_ST;
          EOC_ST: begin
            if (col_idx_q == CW'(MUX - 1)) begin
              state_d   = IDLE;
              col_idx_d = '0;
            end else begin
              col_idx_d = col_idx_q + CW'(1);
              state_d   = LOAD;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  assign bus.sout    = (state_q == SHIFT) ? w_msb : '0;
  assign bus.sclk_en = (state_q == SHIFT);
  assign bus.lat     = (state_q == LATCH);
  assign bus.EOC     = (state_q == EOC_ST);
  assign bus.busy    = (state_q != IDLE);
  assign bus.col_idx = col_idx_q;

endmodule
`default_nettype wire

// File: doc/column_serializer.md
COLUMN_SERIALIZER -- requirements
Module: column_serializer

Interface
REQ-001 SHALL have parameter N_DRIVERS, default 16, number of LED drivers / serial lanes.
REQ-002 SHALL have parameter BITS, default 24, bits per pixel word per driver (RGB 8:8:8).
REQ-003 SHALL have parameter MUX, default 8, columns per frame (multiplexing factor).
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port clk_enable  input  1  qualifies every state/counter advance.
REQ-007 SHALL have port data_in  input  N_DRIVERS*BITS (384)  column buffer from the framebuffer.
REQ-008 SHALL have port driver_SOF  input  1  start-of-frame pulse from the framebuffer.
REQ-009 SHALL have port EOC  output  1  end-of-column; tells the framebuffer to swap buffers.
REQ-010 SHALL have port sout  output  N_DRIVERS  serial data, one lane per driver.
REQ-011 SHALL have port sclk_en  output  1  high while sout carries valid shift bits.
REQ-012 SHALL have port lat  output  1  driver latch strobe.
REQ-013 SHALL have port col_idx  output  $clog2(MUX) (3)  column currently shifted/latched.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL implement states IDLE, LOAD, SHIFT, LATCH, EOC_ST; all outputs registered or decoded from registered state.
REQ-016 SHALL advance state, bit counter and col_idx only on edges where clk_enable=1; otherwise hold everything (EOC, lat stay asserted until an enabled edge).
REQ-017 IDLE: driver_SOF=1 and clk_enable=1 -> LOAD, col_idx<=0.
REQ-018 LOAD: capture data_in into shift register, bit_cnt<=0 -> SHIFT.
REQ-019 SHIFT: lane d outputs data_in[BITS*d+BITS-1 : BITS*d], MSB first, one bit per enabled edge; sclk_en=1; after BITS bits (bit_cnt==BITS-1) -> LATCH.
REQ-020 LATCH: lat=1, sclk_en=0, sout=0 -> EOC_ST.
REQ-021 EOC_ST: EOC=1; on enabled edge: col_idx==MUX-1 -> IDLE, col_idx<=0; else col_idx<=col_idx+1 -> LOAD.
REQ-022 SHALL rely on the framebuffer swapping on the EOC edge, so data_in sampled in LOAD is the next column; no extra wait state.
REQ-023 Column period SHALL be exactly BITS+3 enabled cycles (LOAD 1, SHIFT BITS, LATCH 1, EOC 1) = 27 at defaults.
REQ-024 sout SHALL be 0 and sclk_en 0 outside SHIFT.
REQ-025 driver_SOF with clk_enable=1 in any non-IDLE state SHALL abort the current column (no lat, no EOC) and go to LOAD with col_idx<=0.
REQ-026 driver_SOF with clk_enable=0 SHALL be ignored.
REQ-027 bit_cnt width $clog2(BITS); col_idx wraps MUX-1 -> 0 only through IDLE.
REQ-028 At most one of lat, EOC, sclk_en SHALL be high in any cycle.

Reset
REQ-029 nrst=0 SHALL immediately force IDLE, EOC=0, lat=0, sclk_en=0, sout=0, col_idx=0, busy=0, bit_cnt=0, shift register=0.
REQ-030 Reset asserted mid-SHIFT SHALL discard the column; after release no EOC until a new driver_SOF.

Verification
REQ-031 clk_enable=1, data_in word d = 24'hA50000|d, pulse driver_SOF -> lane 3 shifts 1010_0101_0000_0000_0000_0011 MSB first over 24 cycles, lat at cycle 26, EOC at cycle 27 after SOF edge.
REQ-032 Full frame with constant clk_enable -> exactly 8 EOC pulses, col_idx 0..7, busy falls after 8*27=216 cycles, then IDLE.
REQ-033 clk_enable toggling 1-0 -> every phase duration doubles; EOC held 2 clocks and counted once by framebuffer model.
REQ-034 driver_SOF during column 4 SHIFT bit 10 -> no lat/EOC for column 4, next cycle LOAD, col_idx=0.
REQ-035 nrst low during LATCH of column 2 -> all outputs 0 asynchronously; no activity after release until driver_SOF.
REQ-036 Change data_in after LOAD -> shifted bits unaffected (captured copy used).
